bin_to_bcd_seq: RTL and testbench

- Sequential binary-to-BCD converter using iterative double-dabble (shift-and-add-3).
- Sits directly upstream of the 4-digit seven-segment driver and feeds its d0..d3 digit inputs.
- d0 is the thousands digit and d3 is the ones digit; the driver shows d3 on the rightmost anode.
- Converts an unsigned value 0..9999 on a start pulse, then holds the digits stable until the next conversion completes.

---
 rtl/seg_pkg.sv | 15 +
 rtl/bin_to_bcd_seq_if.sv | 26 ++
 rtl/bcd_add3.sv | 10 +
 rtl/bin_to_bcd_seq.sv | 132 +++++++++++++
 tb/tb_bin_to_bcd_seq.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/seg_pkg.sv
// Shared constants and FSM state type for the seven-segment display path.
// DIGIT_BLANK matches the code the seven_seg_driver renders as an unlit digit.
package seg_pkg;

    localparam logic [3:0] DIGIT_BLANK = 4'hF;
    localparam int         MAX_DISPLAY = 9999;
    localparam int         NUM_DIGITS  = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/bin_to_bcd_seq_if.sv
// Request/result bundle between a binary value source and the BCD converter.
// The master side issues start/value; the slave side (converter) returns status and digits.
interface bin_to_bcd_seq_if #(
    parameter int IN_WIDTH = 14
);
    logic                start;
    logic [IN_WIDTH-1:0] value;
    logic                busy;
    logic                done;
    logic                ovf;
    logic [3:0]          d0;
    logic [3:0]          d1;
    logic [3:0]          d2;
    logic [3:0]          d3;

    modport master (
        output start, value,
        input  busy, done, ovf, d0, d1, d2, d3
    );

    modport slave (
        input  start, value,
        output busy, done, ovf, d0, d1, d2, d3
    );

endinterface

// File: rtl/bcd_add3.sv
// Double-dabble correction step: a BCD nibble of 5 or more gets +3 before the
// next left shift so that the doubled digit carries correctly into the next decade.
module bcd_add3 (
    input  logic [3:0] i_nibble,
    output logic [3:0] o_nibble
);

    assign o_nibble = (i_nibble >= 4'd5) ? (i_nibble + 4'd3) : i_nibble;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Iterative double-dabble binary-to-BCD converter feeding the 4-digit display driver.
// Optional build macro LEADING_ZERO_BLANK_EN blanks leading zero digits d0..d2.
module bin_to_bcd_seq
    import seg_pkg::*;
#(
    parameter int IN_WIDTH  = 14,
    parameter int MAX_VALUE = MAX_DISPLAY
) (
    input logic             clk,
    input logic             rst,
    bin_to_bcd_seq_if.slave bus
);

    localparam int SR_W  = 16 + IN_WIDTH;
    localparam int CNT_W = $clog2(IN_WIDTH + 1);
    localparam logic [IN_WIDTH-1:0] MAX_V = IN_WIDTH'(MAX_VALUE);

    state_t              r_state;
    state_t              w_nextState;
    logic [SR_W-1:0]     r_shift;
    logic [CNT_W-1:0]    r_count;
    logic                r_ovfPending;
    logic                r_done;
    logic                r_ovf;
    logic [15:0]         r_digits;

    logic [15:0]         w_bcd;
    logic [15:0]         w_bcdAdj;
    logic [SR_W-1:0]     w_preShift;
    logic [SR_W-1:0]     w_shiftNext;
    logic [15:0]         w_outDigits;

    assign w_bcd = r_shift[SR_W-1:IN_WIDTH];

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_add3
        bcd_add3 u_add3 (
            .i_nibble (w_bcd[4*g +: 4]),
            .o_nibble (w_bcdAdj[4*g +: 4])
        );
    end

    assign w_preShift  = {w_bcdAdj, r_shift[IN_WIDTH-1:0]};
    assign w_shiftNext = w_preShift << 1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (bus.start) w_nextState = SHIFT;
            SHIFT:   if (r_count == CNT_W'(1)) w_nextState = DONE;
            DONE:    w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

`ifdef LEADING_ZERO_BLANK_EN
    logic w_leading;

    // Blank zeros from the thousands digit down until the first nonzero; ones digit always shows.
    always_comb begin
        w_outDigits = w_bcd;
        w_leading   = 1'b1;
        if (r_ovfPending) begin
            w_outDigits = {NUM_DIGITS{DIGIT_BLANK}};
        end else begin
            for (int i = 0; i < NUM_DIGITS - 1; i++) begin
                if (w_leading && (w_bcd[15-4*i -: 4] == 4'd0)) begin
                    w_outDigits[15-4*i -: 4] = DIGIT_BLANK;
                end else begin
                    w_leading = 1'b0;
                end
            end
        end
    end
`else
    always_comb begin
        w_outDigits = w_bcd;
        if (r_ovfPending) begin
            w_outDigits = {NUM_DIGITS{DIGIT_BLANK}};
        end
    end
`endif

    // Displayed digits and ovf only move on the DONE edge so the driver never sees partial results.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_shift      <= '0;
            r_count      <= '0;
            r_ovfPending <= 1'b0;
            r_done       <= 1'b0;
            r_ovf        <= 1'b0;
            r_digits     <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_shift      <= {16'd0, bus.value};
                        r_count      <= CNT_W'(IN_WIDTH);
                        r_ovfPending <= (bus.value > MAX_V);
                    end
                end
                SHIFT: begin
                    r_shift <= w_shiftNext;
                    r_count <= r_count - CNT_W'(1);
                end
                DONE: begin
                    r_digits <= w_outDigits;
                    r_ovf    <= r_ovfPending;
                    r_done   <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy = (r_state != IDLE);
    assign bus.done = r_done;
    assign bus.ovf  = r_ovf;
    assign bus.d0   = r_digits[15:12];
    assign bus.d1   = r_digits[11:8];
    assign bus.d2   = r_digits[7:4];
    assign bus.d3   = r_digits[3:0];

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed self-checking bench for bin_to_bcd_seq; expectations follow LEADING_ZERO_BLANK_EN.
module tb_bin_to_bcd_seq;

    logic clk;
    logic rst;
    int   nChecks;
    int   nPass;
    int   lat;
    int   busyCycles;
    int   doneCnt;

    bin_to_bcd_seq_if #(.IN_WIDTH(14)) bus ();

    bin_to_bcd_seq #(.IN_WIDTH(14), .MAX_VALUE(9999)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        assert (obs === exp) nPass++;
        else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic applyStimulus(input logic [13:0] v);
        bus.start = 1'b1;
        bus.value = v;
        tick();
        bus.start = 1'b0;
        bus.value = 14'($urandom);
    endtask

    // Waits for done, counting busy cycles; bounded so a stuck DUT shows up as a latency failure.
    task automatic waitDone(output int latency, output int busyCnt);
        latency = 0;
        busyCnt = 0;
        while (bus.done !== 1'b1 && latency < 40) begin
            if (bus.busy === 1'b1) busyCnt++;
            tick();
            latency++;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [15:0] expDigits, input logic expOvf);
        check({tag, "_digits"}, {16'd0, bus.d0, bus.d1, bus.d2, bus.d3}, {16'd0, expDigits});
        check({tag, "_ovf"}, {31'd0, bus.ovf}, {31'd0, expOvf});
    endtask

    function automatic logic [15:0] refDigits(input int v);
        logic [15:0] d;
        logic        lead;
        if (v > 9999) return 16'hFFFF;
        d = {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
`ifdef LEADING_ZERO_BLANK_EN
        lead = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (lead && d[15-4*i -: 4] == 4'd0) d[15-4*i -: 4] = 4'hF;
            else lead = 1'b0;
        end
`else
        lead = 1'b0;
`endif
        return d;
    endfunction

    initial begin
        int v;
        int nv;
        nChecks   = 0;
        nPass     = 0;
        bus.start = 1'b0;
        bus.value = '0;
        rst       = 1'b1;
        tick();
        tick();
        rst = 1'b0;

        check("reset_busy", {31'd0, bus.busy}, 32'd0);
        check("reset_done", {31'd0, bus.done}, 32'd0);
        checkOutput("reset", 16'h0000, 1'b0);

        applyStimulus(14'd1234);
        waitDone(lat, busyCycles);
        check("lat_1234", lat, 15);
        check("busy_1234", busyCycles, 15);
        checkOutput("v1234", 16'h1234, 1'b0);
        tick();
        check("done_pulse_1234", {31'd0, bus.done}, 32'd0);
        checkOutput("hold_1234", 16'h1234, 1'b0);

        applyStimulus(14'd9999);
        waitDone(lat, busyCycles);
        check("lat_9999", lat, 15);
        checkOutput("v9999", 16'h9999, 1'b0);
        tick();

        applyStimulus(14'd0);
        waitDone(lat, busyCycles);
`ifdef LEADING_ZERO_BLANK_EN
        checkOutput("v0", 16'hFFF0, 1'b0);
`else
        checkOutput("v0", 16'h0000, 1'b0);
`endif
        tick();

        applyStimulus(14'd10000);
        waitDone(lat, busyCycles);
        check("lat_10000", lat, 15);
        checkOutput("v10000", 16'hFFFF, 1'b1);
        tick();
        checkOutput("hold_ovf", 16'hFFFF, 1'b1);

        applyStimulus(14'd42);
        waitDone(lat, busyCycles);
`ifdef LEADING_ZERO_BLANK_EN
        checkOutput("v42", 16'hFF42, 1'b0);
`else
        checkOutput("v42", 16'h0042, 1'b0);
`endif
        tick();

        // Starts during an active conversion must be dropped, not queued.
        applyStimulus(14'd500);
        doneCnt = 0;
        for (int cyc = 1; cyc <= 30; cyc++) begin
            bus.start = (cyc == 3 || cyc == 7);
            bus.value = 14'd1111;
            tick();
            if (bus.done === 1'b1) doneCnt++;
        end
        bus.start = 1'b0;
        check("ignored_start_dones", doneCnt, 1);
`ifdef LEADING_ZERO_BLANK_EN
        checkOutput("v500", 16'hF500, 1'b0);
`else
        checkOutput("v500", 16'h0500, 1'b0);
`endif

        applyStimulus(14'd7777);
        for (int cyc = 1; cyc < 8; cyc++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_busy", {31'd0, bus.busy}, 32'd0);
        check("abort_done", {31'd0, bus.done}, 32'd0);
        checkOutput("abort", 16'h0000, 1'b0);
        doneCnt = 0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            tick();
            if (bus.done === 1'b1) doneCnt++;
        end
        check("abort_no_done", doneCnt, 0);

        applyStimulus(14'd7777);
        waitDone(lat, busyCycles);
        check("lat_7777", lat, 15);
        checkOutput("v7777", 16'h7777, 1'b0);

        // Back-to-back sweep: next start goes in during the done cycle.
        tick();
        v = int'($urandom_range(9999));
        applyStimulus(14'(v));
        for (int k = 0; k < 20; k++) begin
            waitDone(lat, busyCycles);
            check("sweep_lat", lat, 15);
            check("sweep_digits", {16'd0, bus.d0, bus.d1, bus.d2, bus.d3}, {16'd0, refDigits(v)});
            check("sweep_ovf", {31'd0, bus.ovf}, 32'd0);
            if (k < 19) begin
                nv = int'($urandom_range(9999));
                v  = nv;
                applyStimulus(14'(nv));
            end
        end

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
